// File: rtl/p88_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// p88_load_sequencer_if
//   Shared memory write port driven by the P88 load sequencer and consumed by
//   the top-level RAM/ROM mux.
//
//   Signals
//     mem_req   sequencer -> memory   write request, held until mem_ack
//     mem_rom   sequencer -> memory   target select: 0 = DRAM, 1 = boot ROM
//     mem_addr  sequencer -> memory   write address (ADDR_W bits)
//     mem_data  sequencer -> memory   write data byte
//     mem_ack   memory -> sequencer   write completed (may come in the request cycle)
//
//   Modports
//     master    the sequencer side
//     slave     the memory / mux side
// ---------------------------------------------------------------------------
interface p88_load_sequencer_if #(
  parameter int ADDR_W = 18
) ();

  logic              mem_req;
  logic              mem_rom;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_rom,
    output mem_addr,
    output mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_rom,
    input  mem_addr,
    input  mem_data,
    output mem_ack
  );

endinterface

// File: rtl/p88_load_sequencer.sv
// ---------------------------------------------------------------------------
// p88_load_sequencer
//   Parses the P88 program image arriving on the ioctl download byte stream
//   and turns it into single-byte writes to DRAM (0xC8 records) or to the
//   boot ROM far-JMP reset vector (0xCA records). The system is held in reset
//   for the whole load.
//
//   Parameters
//     ADDR_W      DRAM write address width (must be <= 20)
//     ROM_ADDR_W  boot ROM address width
//     VEC_BASE    ROM address of the first reset-vector byte
//
//   Ports
//     clk_sys         in   system clock, rising edge
//     reset           in   synchronous active-high reset
//     ioctl_download  in   high for the whole image download
//     ioctl_wr        in   one-cycle byte strobe
//     ioctl_dout      in   image byte
//     ioctl_wait      out  stall request to the byte source
//     cpu_reset_hold  out  system reset request while loading
//     load_error      out  sticky error, cleared when a new download starts
//     mem             master side of the shared memory write port
// ---------------------------------------------------------------------------
module p88_load_sequencer #(
  parameter int ADDR_W     = 18,
  parameter int ROM_ADDR_W = 3,
  parameter int VEC_BASE   = 0
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ioctl_download,
  input  logic                        ioctl_wr,
  input  logic [7:0]                  ioctl_dout,
  output logic                        ioctl_wait,
  output logic                        cpu_reset_hold,
  output logic                        load_error,
  p88_load_sequencer_if.master        mem
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_HDR8, S_HDRA, S_DATA, S_WR, S_WREL, S_VEC, S_VWR, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              dl_q;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;   // download ended while a write was in flight
  logic [2:0]        cnt_q, cnt_d;     // header byte index
  logic [15:0]       seg_q, seg_d;
  logic [15:0]       off_q, off_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        idx_q, idx_d;     // reset-vector byte index 0..4

  logic              busy;
  logic              byte_acc;
  logic              dl_rise, dl_fall;
  logic              end_now;
  logic [19:0]       lin_w;
  logic [ROM_ADDR_W-1:0] rom_addr_w;
  logic [7:0]        vec_byte;

  // States in which a memory handshake is in progress; the byte source is
  // stalled and a new download start cannot take over.
  assign busy     = (state_q inside {S_WR, S_WREL, S_VEC, S_VWR});
  assign byte_acc = ioctl_wr & ~busy;
  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign end_now  = pend_q | dl_fall;

  // Real-mode linear address, wrapping at 1 MiB.
  assign lin_w = {seg_q, 4'h0} + {4'h0, off_q};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      seg_q   <= '0;
      off_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      hold_q  <= hold_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      off_q   <= off_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    off_d   = off_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: ;

      S_CMD: begin
        if (byte_acc) begin
          cnt_d = 3'd0;
          if (ioctl_dout == 8'hC8) begin
            state_d = S_HDR8;
          end else if (ioctl_dout == 8'hCA) begin
            state_d = S_HDRA;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      // Both header types share the seg/off layout; HDR8 adds two skip bytes
      // and the length.
      S_HDR8, S_HDRA: begin
        if (byte_acc) begin
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd0:    seg_d[7:0]  = ioctl_dout;
            3'd1:    seg_d[15:8] = ioctl_dout;
            3'd2:    off_d[7:0]  = ioctl_dout;
            3'd3:    off_d[15:8] = ioctl_dout;
            3'd6:    len_d[7:0]  = ioctl_dout;
            3'd7:    len_d[15:8] = ioctl_dout;
            default: ;
          endcase
          if (state_q == S_HDRA && cnt_q == 3'd3) begin
            idx_d   = 3'd0;
            state_d = S_VEC;
          end
          if (state_q == S_HDR8 && cnt_q == 3'd7) begin
            addr_d  = lin_w[ADDR_W-1:0];
            state_d = ({ioctl_dout, len_q[7:0]} == 16'd0) ? S_CMD : S_DATA;
          end
        end
      end

      S_DATA: begin
        if (byte_acc) begin
          data_d  = ioctl_dout;
          state_d = S_WR;
        end
      end

      S_WR: begin
        if (mem.mem_ack) begin
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q - 16'd1;
          state_d = S_WREL;
        end
      end

      // One extra stall cycle after the ack gives the 3-clock byte period.
      S_WREL: begin
        if (end_now) begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d = (len_q == 16'd0) ? S_CMD : S_DATA;
        end
      end

      S_VEC: state_d = S_VWR;

      S_VWR: begin
        if (mem.mem_ack) begin
          if (idx_q == 3'd4) begin
            if (end_now) begin
              state_d = S_IDLE;
              hold_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              state_d = S_CMD;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_VEC;
          end
        end
      end

      S_ERR: err_d = 1'b1;

      default: state_d = S_IDLE;
    endcase

    // Download edges override the byte-driven step. A new start is not
    // honoured mid-handshake so a write is never torn.
    if (dl_rise && !busy) begin
      state_d = S_CMD;
      hold_d  = 1'b1;
      err_d   = 1'b0;
    end else if (dl_fall) begin
      case (state_q)
        S_CMD, S_ERR: begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
        end
        S_HDR8, S_HDRA, S_DATA: begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
          err_d   = 1'b1;
        end
        S_WR, S_VEC, S_VWR: pend_d = 1'b1;
        default: ;
      endcase
    end

    if (state_d == S_IDLE) pend_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state, so stable for a whole cycle)
  // -------------------------------------------------------------------------
  assign rom_addr_w = ROM_ADDR_W'(VEC_BASE) + ROM_ADDR_W'(idx_q);

  always_comb begin
    case (idx_q)
      3'd0:    vec_byte = 8'hEA;          // far JMP opcode
      3'd1:    vec_byte = off_q[7:0];
      3'd2:    vec_byte = off_q[15:8];
      3'd3:    vec_byte = seg_q[7:0];
      default: vec_byte = seg_q[15:8];
    endcase
  end

  always_comb begin
    ioctl_wait     = busy;
    cpu_reset_hold = hold_q;
    load_error     = err_q;
    mem.mem_req    = (state_q == S_WR) || (state_q == S_VWR);
    mem.mem_rom    = (state_q == S_VEC) || (state_q == S_VWR);
    mem.mem_addr   = addr_q;
    mem.mem_data   = data_q;
    if (mem.mem_rom) begin
      mem.mem_addr = ADDR_W'(rom_addr_w);
      mem.mem_data = vec_byte;
    end
  end

endmodule

// File: tb/tb_p88_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_p88_load_sequencer
//   Table of hand-computed images, hand sequences for download aborts and
//   reset, then random images checked against a byte-stream parser model.
// ---------------------------------------------------------------------------
module tb_p88_load_sequencer;

  typedef logic [7:0]  bq_t[$];
  typedef logic [26:0] wq_t[$];

  typedef struct {
    logic [7:0]  img [32];
    int          n;
    int          dly;
    bit          err;
    logic [26:0] wr [8];
    int          nwr;
  } vec_t;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_dout;
  logic       ioctl_wait;
  logic       cpu_reset_hold;
  logic       load_error;

  p88_load_sequencer_if #(.ADDR_W(18)) mem_if ();

  p88_load_sequencer #(.ADDR_W(18), .ROM_ADDR_W(3), .VEC_BASE(0)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cpu_reset_hold (cpu_reset_hold),
    .load_error     (load_error),
    .mem            (mem_if)
  );

  always #5 clk_sys = ~clk_sys;

  int   n_vec = 0;
  int   n_miss = 0;
  int   ack_dly = 0;
  int   req_cnt = 0;
  int   last_len = 0;
  wq_t  wr_log;
  vec_t vt [8];
  int   n_tab = 0;

  // Memory responder: acks after ack_dly extra cycles of request.
  always_ff @(posedge clk_sys) begin
    if (mem_if.mem_req && !mem_if.mem_ack) req_cnt <= req_cnt + 1;
    else                                   req_cnt <= 0;
  end
  always_comb mem_if.mem_ack = mem_if.mem_req && (req_cnt >= ack_dly);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] mk(input bit rom, input int addr, input logic [7:0] d);
    return {rom, 18'(addr), d};
  endfunction

  // Write monitor: logs completed writes, checks bus stability and that the
  // system stays in reset while a write is requested.
  initial begin
    bit          prev_req = 0, prev_ack = 0;
    logic [26:0] prev_bus = '0, cur_bus;
    int          cur_len = 0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_req = 0; prev_ack = 0; cur_len = 0;
      end else begin
        cur_bus = {mem_if.mem_rom, mem_if.mem_addr, mem_if.mem_data};
        if (mem_if.mem_req) begin
          chk("hold_during_req", 32'(cpu_reset_hold), 1);
          if (prev_req && !prev_ack) chk("bus_stable", 32'(cur_bus), 32'(prev_bus));
          cur_len++;
          if (mem_if.mem_ack) begin
            wr_log.push_back(cur_bus);
            last_len = cur_len;
            cur_len  = 0;
          end
        end else begin
          cur_len = 0;
        end
        prev_req = mem_if.mem_req;
        prev_ack = mem_if.mem_ack;
        prev_bus = cur_bus;
      end
    end
  end

  // Reference parser: walks the image record by record.
  function automatic void model(input bq_t img, output bit err, output wq_t wr);
    int          i = 0;
    int          n = img.size();
    bit          stop = 0;
    logic [15:0] seg, off, len;
    int          lin;
    logic [7:0]  vb [5];
    err = 0;
    wr.delete();
    while (i < n && !stop) begin
      logic [7:0] c = img[i];
      i++;
      if (c == 8'hC8) begin
        if (n - i < 8) begin
          err = 1; stop = 1;
        end else begin
          seg = {img[i+1], img[i]};
          off = {img[i+3], img[i+2]};
          len = {img[i+7], img[i+6]};
          i += 8;
          lin = (int'(seg) * 16 + int'(off)) % (1 << 20);
          for (int k = 0; k < int'(len) && !stop; k++) begin
            if (i >= n) begin
              err = 1; stop = 1;
            end else begin
              wr.push_back(mk(1'b0, (lin + k) % (1 << 18), img[i]));
              i++;
            end
          end
        end
      end else if (c == 8'hCA) begin
        if (n - i < 4) begin
          err = 1; stop = 1;
        end else begin
          vb = '{8'hEA, img[i+2], img[i+3], img[i], img[i+1]};
          i += 4;
          for (int k = 0; k < 5; k++) wr.push_back(mk(1'b1, (0 + k) % 8, vb[k]));
        end
      end else begin
        err = 1; stop = 1;
      end
    end
  endfunction

  task automatic add_vec(input bq_t img, input int dly, input bit err, input wq_t wr);
    vt[n_tab].n   = img.size();
    vt[n_tab].dly = dly;
    vt[n_tab].err = err;
    vt[n_tab].nwr = wr.size();
    for (int j = 0; j < img.size(); j++) vt[n_tab].img[j] = img[j];
    for (int j = 0; j < wr.size(); j++)  vt[n_tab].wr[j]  = wr[j];
    n_tab++;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit junk);
    int t = 0;
    while (ioctl_wait && t < 300) begin
      if (junk && $urandom_range(0, 1) == 1) begin
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'($urandom);
      end else begin
        ioctl_wr = 1'b0;
      end
      @(posedge clk_sys); #1;
      t++;
    end
    ioctl_wr = 1'b0;
    if (t >= 300) chk("wait_release", 32'(ioctl_wait), 0);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    chk("start_hold", 32'(cpu_reset_hold), 1);
    chk("start_err_clear", 32'(load_error), 0);
  endtask

  task automatic wait_hold_low();
    int t = 0;
    while (cpu_reset_hold && t < 300) begin
      @(posedge clk_sys); #1;
      t++;
    end
    chk("hold_release", 32'(cpu_reset_hold), 0);
  endtask

  task automatic end_dl();
    int t = 0;
    while (ioctl_wait && t < 300) begin
      @(posedge clk_sys); #1;
      t++;
    end
    ioctl_download = 1'b0;
    wait_hold_low();
    @(posedge clk_sys); #1;
  endtask

  task automatic run_image(input bq_t img, input int dly, input bit junk,
                           output bit err, output wq_t wr);
    ack_dly = dly;
    wr_log.delete();
    start_dl();
    foreach (img[j]) send_byte(img[j], junk);
    end_dl();
    err = load_error;
    wr  = wr_log;
  endtask

  task automatic cmp_run(input string tag, input bit err, input wq_t wr,
                         input bit eerr, input wq_t ewr);
    chk({tag, "_err"}, 32'(err), 32'(eerr));
    chk({tag, "_nwr"}, wr.size(), ewr.size());
    for (int j = 0; j < wr.size() && j < ewr.size(); j++)
      chk($sformatf("%s_wr%0d", tag, j), 32'(wr[j]), 32'(ewr[j]));
  endtask

  initial begin
    bq_t         q8;
    wq_t         qw, ew, got_wr;
    bit          got_err, eerr;
    logic [15:0] seg, off, len;
    logic [7:0]  b;
    int          nrec, sel, ntr;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00;

    // Table of images with hand-derived expectations.
    q8 = '{8'hC8, 8'h10, 8'h00, 8'h04, 8'h00, 8'hAA, 8'hBB, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33,
           8'hCA, 8'h00, 8'hF0, 8'h00, 8'h00};
    qw = '{mk(0, 'h104, 8'h11), mk(0, 'h105, 8'h22), mk(0, 'h106, 8'h33),
           mk(1, 0, 8'hEA), mk(1, 1, 8'h00), mk(1, 2, 8'h00), mk(1, 3, 8'h00), mk(1, 4, 8'hF0)};
    add_vec(q8, 0, 0, qw);
    add_vec(q8, 5, 0, qw);
    q8 = '{8'hC8, 8'hFF, 8'hFF, 8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h5A, 8'hA5};
    qw = '{mk(0, 'h10, 8'h5A), mk(0, 'h11, 8'hA5)};
    add_vec(q8, 0, 0, qw);
    q8 = '{8'h55, 8'h01, 8'h02, 8'h03};
    qw.delete();
    add_vec(q8, 0, 1, qw);
    q8 = '{8'hC8, 8'h10, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h03};
    add_vec(q8, 0, 1, qw);
    q8 = '{8'hC8, 8'hFF, 8'h3F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h77, 8'h88};
    qw = '{mk(0, 'h3FFFF, 8'h77), mk(0, 'h00000, 8'h88)};
    add_vec(q8, 1, 0, qw);
    q8 = '{8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'hCA, 8'h34, 8'h12, 8'h78, 8'h56};
    qw = '{mk(1, 0, 8'hEA), mk(1, 1, 8'h78), mk(1, 2, 8'h56), mk(1, 3, 8'h34), mk(1, 4, 8'h12)};
    add_vec(q8, 2, 0, qw);
    q8 = '{8'hC8, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h9C, 8'h33, 8'h44};
    qw = '{mk(0, 'h1, 8'h9C)};
    add_vec(q8, 1, 1, qw);

    // Reset state.
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_hold", 32'(cpu_reset_hold), 0);
    chk("rst_err", 32'(load_error), 0);
    chk("rst_req", 32'(mem_if.mem_req), 0);
    chk("rst_rom", 32'(mem_if.mem_rom), 0);
    chk("rst_addr", 32'(mem_if.mem_addr), 0);
    chk("rst_data", 32'(mem_if.mem_data), 0);
    reset = 1'b0;
    @(posedge clk_sys); #1;

    for (int k = 0; k < n_tab; k++) begin
      q8.delete();
      ew.delete();
      for (int j = 0; j < vt[k].n; j++)   q8.push_back(vt[k].img[j]);
      for (int j = 0; j < vt[k].nwr; j++) ew.push_back(vt[k].wr[j]);
      run_image(q8, vt[k].dly, vt[k].dly == 5, got_err, got_wr);
      cmp_run($sformatf("vec%0d", k), got_err, got_wr, vt[k].err, ew);
      if (vt[k].dly == 5) chk("req_len6", last_len, 6);
      $display("table vector %0d: %0d bytes, %0d writes, load_error=%0d", k, vt[k].n, got_wr.size(), got_err);
    end

    // Download ends while a DRAM write waits for its ack.
    ack_dly = 5;
    wr_log.delete();
    start_dl();
    q8 = '{8'hC8, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h44};
    foreach (q8[j]) send_byte(q8[j], 0);
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    chk("fall_wr_hold_kept", 32'(cpu_reset_hold), 1);
    wait_hold_low();
    chk("fall_wr_err", 32'(load_error), 1);
    chk("fall_wr_nwr", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("fall_wr_wr0", 32'(wr_log[0]), 32'(mk(0, 'h100, 8'h44)));
    $display("hand sequence fall-in-WR: %0d writes, load_error=%0d", wr_log.size(), load_error);

    // Download ends right after a reset-vector header: all five ROM bytes still land.
    ack_dly = 3;
    wr_log.delete();
    start_dl();
    q8 = '{8'hCA, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (q8[j]) send_byte(q8[j], 0);
    ioctl_download = 1'b0;
    wait_hold_low();
    ew = '{mk(1, 0, 8'hEA), mk(1, 1, 8'h33), mk(1, 2, 8'h44), mk(1, 3, 8'h11), mk(1, 4, 8'h22)};
    cmp_run("fall_vec", load_error, wr_log, 1, ew);
    $display("hand sequence fall-in-VEC: %0d writes, load_error=%0d", wr_log.size(), load_error);

    // Reset while a write is requested.
    ack_dly = 20;
    wr_log.delete();
    start_dl();
    q8 = '{8'hC8, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h55};
    foreach (q8[j]) send_byte(q8[j], 0);
    chk("pre_reset_req", 32'(mem_if.mem_req), 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    chk("reset_req", 32'(mem_if.mem_req), 0);
    chk("reset_wait", 32'(ioctl_wait), 0);
    chk("reset_hold", 32'(cpu_reset_hold), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    $display("hand sequence reset-during-write: mem_req=%0d ioctl_wait=%0d", mem_if.mem_req, ioctl_wait);

    // Random images against the parser model.
    for (int r = 0; r < 40; r++) begin
      q8.delete();
      nrec = $urandom_range(1, 3);
      for (int k = 0; k < nrec; k++) begin
        sel = $urandom_range(0, 7);
        seg = 16'($urandom);
        off = 16'($urandom);
        if (sel <= 4) begin
          len = 16'($urandom_range(0, 4));
          q8.push_back(8'hC8);
          q8.push_back(seg[7:0]); q8.push_back(seg[15:8]);
          q8.push_back(off[7:0]); q8.push_back(off[15:8]);
          q8.push_back(8'($urandom)); q8.push_back(8'($urandom));
          q8.push_back(len[7:0]); q8.push_back(len[15:8]);
          for (int j = 0; j < int'(len); j++) q8.push_back(8'($urandom));
        end else if (sel <= 6) begin
          q8.push_back(8'hCA);
          q8.push_back(seg[7:0]); q8.push_back(seg[15:8]);
          q8.push_back(off[7:0]); q8.push_back(off[15:8]);
        end else begin
          b = 8'($urandom);
          if (b == 8'hC8 || b == 8'hCA) b = 8'h00;
          q8.push_back(b);
          q8.push_back(8'($urandom));
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        ntr = $urandom_range(1, 3);
        while (ntr > 0 && q8.size() > 0) begin
          void'(q8.pop_back());
          ntr--;
        end
      end
      model(q8, eerr, ew);
      run_image(q8, $urandom_range(0, 3), 1, got_err, got_wr);
      cmp_run($sformatf("rand%0d", r), got_err, got_wr, eerr, ew);
      $display("random image %0d: %0d bytes, %0d writes (model %0d), load_error=%0d (model %0d)",
               r, q8.size(), got_wr.size(), ew.size(), got_err, eerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
